// File: rtl/pio_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sap1_pio_pkg
// Purpose  : Shared types and default constants for the PIO arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sap1_pio_pkg;

    localparam int unsigned c_DEF_TIMEOUT_CYCLES = 64;
    localparam logic [31:0] c_DEF_ERR_DATA       = 32'hDEAD_BEEF;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } pio_state_t;

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [31:0] data_w;
    } pio_cmd_t;

endpackage
`default_nettype wire

// File: rtl/pio_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pio_arbiter_if
// Purpose  : Requester and PIO-side signal bundle of the PIO arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface pio_arbiter_if;

    logic        r0_cmd_vld;
    logic        r0_rw;
    logic [15:0] r0_addr;
    logic [31:0] r0_data_w;
    logic        r0_cmd_rdy;
    logic        r0_rd_vld;
    logic [31:0] r0_data_r;
    logic        r0_rd_err;

    logic        r1_cmd_vld;
    logic        r1_rw;
    logic [15:0] r1_addr;
    logic [31:0] r1_data_w;
    logic        r1_cmd_rdy;
    logic        r1_rd_vld;
    logic [31:0] r1_data_r;
    logic        r1_rd_err;

    logic        pio_cmd_vld;
    logic        pio_rw;
    logic [15:0] pio_addr;
    logic [31:0] pio_data_w;
    logic        pio_rd_vld;
    logic [31:0] pio_data_r;

    // Arbiter-side view
    modport slave (
        input  r0_cmd_vld, r0_rw, r0_addr, r0_data_w,
        output r0_cmd_rdy, r0_rd_vld, r0_data_r, r0_rd_err,
        input  r1_cmd_vld, r1_rw, r1_addr, r1_data_w,
        output r1_cmd_rdy, r1_rd_vld, r1_data_r, r1_rd_err,
        output pio_cmd_vld, pio_rw, pio_addr, pio_data_w,
        input  pio_rd_vld, pio_data_r
    );

    // Requester / PIO-target view
    modport master (
        output r0_cmd_vld, r0_rw, r0_addr, r0_data_w,
        input  r0_cmd_rdy, r0_rd_vld, r0_data_r, r0_rd_err,
        output r1_cmd_vld, r1_rw, r1_addr, r1_data_w,
        input  r1_cmd_rdy, r1_rd_vld, r1_data_r, r1_rd_err,
        input  pio_cmd_vld, pio_rw, pio_addr, pio_data_w,
        output pio_rd_vld, pio_data_r
    );

endinterface
`default_nettype wire

// File: rtl/pio_arbiter_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : pio_rr_arb
// Purpose  : Two-way round-robin grant; a tie goes to the requester that
//            did not win the previous transfer.
// Revision : 1.0 - initial release
// ============================================================================
module pio_rr_arb (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic [1:0] req,
    input  wire logic       advance,
    output logic      [1:0] gnt
);

    logic r_last_grant;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (advance) begin
            r_last_grant <= gnt[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/pio_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pio_arbiter
// Purpose  : Arbitrates two PIO requesters onto one PIO port, tracking a
//            single outstanding read with a response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module pio_arbiter
    import sap1_pio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_DATA       = c_DEF_ERR_DATA
) (
    input wire logic      clk,
    input wire logic      reset,
    pio_arbiter_if.slave  bus
);

    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    pio_state_t  r_state;
    pio_state_t  w_state_nxt;
    logic [7:0]  r_count;
    logic        r_owner;
    logic        r_cmd_vld;
    pio_cmd_t    r_cmd;
    logic [1:0]  r_rd_vld;
    logic [1:0]  r_rd_err;
    logic [31:0] r_data_r [0:1];

    logic [1:0]  w_req;
    logic [1:0]  w_gnt;
    logic        w_xfer;
    logic        w_rd_xfer;
    pio_cmd_t    w_sel_cmd;
    logic        w_resp;
    logic        w_timeout;
    logic        w_done;

    assign w_req = {bus.r1_cmd_vld, bus.r0_cmd_vld} & {2{r_state == ST_IDLE}};

    pio_rr_arb u_rr_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (w_req),
        .advance (w_xfer),
        .gnt     (w_gnt)
    );

    assign w_xfer    = |w_gnt;
    assign w_sel_cmd = w_gnt[1] ? pio_cmd_t'{bus.r1_rw, bus.r1_addr, bus.r1_data_w}
                                : pio_cmd_t'{bus.r0_rw, bus.r0_addr, bus.r0_data_w};
    assign w_rd_xfer = w_xfer && !w_sel_cmd.rw;

    // A real response in the timeout cycle takes precedence over the error.
    assign w_resp    = (r_state == ST_RD_WAIT) && bus.pio_rd_vld;
    assign w_timeout = (r_state == ST_RD_WAIT) && !bus.pio_rd_vld && (r_count == c_TO_LAST);
    assign w_done    = w_resp || w_timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_rd_xfer) w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: if (w_done)    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= 8'd0;
            r_owner     <= 1'b0;
            r_cmd_vld   <= 1'b0;
            r_cmd       <= '0;
            r_rd_vld    <= 2'b00;
            r_rd_err    <= 2'b00;
            r_data_r[0] <= 32'd0;
            r_data_r[1] <= 32'd0;
        end else begin
            r_cmd_vld <= w_xfer;
            if (w_xfer) begin
                r_cmd <= w_sel_cmd;
            end

            if (w_rd_xfer) begin
                r_owner <= w_gnt[1];
                r_count <= 8'd0;
            end else if ((r_state == ST_RD_WAIT) && !w_done) begin
                r_count <= r_count + 8'd1;
            end

            r_rd_vld <= 2'b00;
            if (w_done) begin
                r_rd_vld[r_owner] <= 1'b1;
                r_rd_err[r_owner] <= w_timeout;
                r_data_r[r_owner] <= w_resp ? bus.pio_data_r : ERR_DATA;
            end
        end
    end

    assign bus.r0_cmd_rdy  = w_gnt[0];
    assign bus.r1_cmd_rdy  = w_gnt[1];
    assign bus.r0_rd_vld   = r_rd_vld[0];
    assign bus.r1_rd_vld   = r_rd_vld[1];
    assign bus.r0_rd_err   = r_rd_err[0];
    assign bus.r1_rd_err   = r_rd_err[1];
    assign bus.r0_data_r   = r_data_r[0];
    assign bus.r1_data_r   = r_data_r[1];
    assign bus.pio_cmd_vld = r_cmd_vld;
    assign bus.pio_rw      = r_cmd.rw;
    assign bus.pio_addr    = r_cmd.addr;
    assign bus.pio_data_w  = r_cmd.data_w;

endmodule
`default_nettype wire

// File: doc/pio_arbiter.md
PIO_ARBITER -- requirements
Module: pio_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, read-response timeout in clk cycles; legal range 2..255.
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on timeout.
REQ-003 clk  input  1  clock; all logic on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 rN_cmd_vld  input  1  requester N (N=0,1) command valid.
REQ-006 rN_rw  input  1  requester N direction; 1=write, 0=read.
REQ-007 rN_addr  input  16  requester N PIO address.
REQ-008 rN_data_w  input  32  requester N write data.
REQ-009 rN_cmd_rdy  output  1  requester N command accepted this cycle.
REQ-010 rN_rd_vld  output  1  requester N read response pulse.
REQ-011 rN_data_r  output  32  requester N read data.
REQ-012 rN_rd_err  output  1  requester N read timed out; qualified by rN_rd_vld.
REQ-013 pio_cmd_vld  output  1  PIO command strobe, one cycle per command.
REQ-014 pio_rw  output  1  PIO direction.
REQ-015 pio_addr  output  16  PIO address.
REQ-016 pio_data_w  output  32  PIO write data.
REQ-017 pio_rd_vld  input  1  PIO read response valid.
REQ-018 pio_data_r  input  32  PIO read data.

Function
REQ-019 Handshake: a command transfers on a posedge with rN_cmd_vld=1 and rN_cmd_rdy=1; the requester holds rN_rw/addr/data_w stable until transfer.
REQ-020 FSM states IDLE and RD_WAIT; rN_cmd_rdy is combinational and asserts only in IDLE, for at most one requester (the grant).
REQ-021 Arbitration: one requester valid -> it is granted; both valid -> the one not in last_grant is granted; last_grant updates on every transfer.
REQ-022 On transfer, the next cycle has pio_cmd_vld=1 with pio_rw/addr/data_w equal to the transferred values (1-cycle latency); pio_rw/addr/data_w hold thereafter until the next transfer.
REQ-023 Write transfer: FSM stays IDLE; back-to-back writes sustain one per cycle.
REQ-024 Read transfer: FSM -> RD_WAIT, owner recorded, timeout counter cleared to 0.
REQ-025 RD_WAIT: pio_rd_vld sampled every cycle, including the cycle pio_cmd_vld is high.
REQ-026 RD_WAIT with pio_rd_vld=1 -> next cycle owner rd_vld=1, data_r=pio_data_r, rd_err=0; FSM -> IDLE.
REQ-027 RD_WAIT without pio_rd_vld: counter increments; at counter=TIMEOUT_CYCLES-1 -> next cycle owner rd_vld=1, data_r=ERR_DATA, rd_err=1; FSM -> IDLE.
REQ-028 pio_rd_vld and timeout in the same cycle: response wins, rd_err=0.
REQ-029 pio_rd_vld in IDLE (stray or post-timeout) is ignored; no rN_rd_vld.
REQ-030 rN_rd_vld is a single-cycle pulse, non-owner's rd_vld stays 0; rN_data_r and rN_rd_err hold until the next response for N.
REQ-031 Earliest new grant after a read response: the same cycle rN_rd_vld is high.

Reset
REQ-032 Reset forces FSM=IDLE, counter=0, last_grant=1 (r0 wins first tie), all outputs 0.
REQ-033 Reset during RD_WAIT abandons the read; no rN_rd_vld is produced for it.

Structure
REQ-034 Package sap1_pio_pkg holds the FSM state enum, the default TIMEOUT_CYCLES/ERR_DATA constants and a packed pio_cmd_t struct {rw, addr, data_w}.
REQ-035 Two-way round-robin grant logic lives in sub-module pio_rr_arb (inputs req[1:0], advance, reset; outputs gnt[1:0]); the FSM, counter and datapath live in pio_arbiter.

Verification
REQ-036 r0 write addr 16'h0010 data 32'h1234_5678 alone -> r0_cmd_rdy same cycle; next cycle pio_cmd_vld=1, pio_rw=1, pio_addr=16'h0010, pio_data_w=32'h1234_5678.
REQ-037 r0 and r1 both hold writes for 4 cycles after reset -> grants r0,r1,r0,r1 on consecutive cycles.
REQ-038 r1 read addr 16'h0004; pio_rd_vld=1 with data 32'hCAFE_0001 3 cycles after issue -> r1_rd_vld pulse next cycle, r1_data_r=32'hCAFE_0001, r1_rd_err=0; r0_rd_vld stays 0; r0 held pending until response.
REQ-039 TIMEOUT_CYCLES=4, r0 read, no response -> r0_rd_vld=1, r0_rd_err=1, r0_data_r=32'hDEAD_BEEF 4 cycles after the read is issued (pio_cmd_vld cycle); late pio_rd_vld ignored.
REQ-040 Reset asserted mid-RD_WAIT, then pio_rd_vld=1 -> no rN_rd_vld, all outputs 0, next tie grants r0.
